// File: rtl/uart_mem_pkg.sv
// Shared types for the UART-loader / CPU memory arbiter: FSM states, grant encoding, RAM size.
package uart_mem_pkg;

  localparam int RAM_ADDR_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef enum logic {
    GNT_CPU,
    GNT_LDR
  } gnt_t;

endpackage

// File: rtl/uart_mem_arbiter_if.sv
// One requester port of the arbiter (picorv32 native memory protocol).
// Handshake: the master raises valid with addr/wdata/wstrb stable and holds them
// until ready; ready is a single-cycle pulse; wstrb == 0 means read, and rdata
// is only meaningful in the ready cycle.
interface uart_mem_arbiter_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational 2-way picker: a lone requester always wins; on a tie prio_ldr decides.
module mem_arb_pick
  import uart_mem_pkg::*;
(
  input  logic cpu_valid,
  input  logic ldr_valid,
  input  logic prio_ldr,
  output gnt_t gnt
);

  always_comb begin
    gnt = GNT_CPU;
    if (ldr_valid && (!cpu_valid || prio_ldr)) gnt = GNT_LDR;
  end

endmodule

// File: rtl/uart_mem_arbiter.sv
// Arbitrates the CPU and UART loader onto one single-port synchronous RAM (IDLE/ACCESS/RESP).
// Optional macro ARB_ROUND_ROBIN_EN: ties alternate instead of using LoaderFirst.
module uart_mem_arbiter
  import uart_mem_pkg::*;
#(
  parameter int AddrWidth   = RAM_ADDR_WIDTH,
  parameter bit LoaderFirst = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 cpu_valid_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_wdata_i,
  input  logic [3:0]           cpu_wstrb_i,
  output logic                 cpu_ready_o,
  output logic [31:0]          cpu_rdata_o,
  input  logic                 ldr_valid_i,
  input  logic [31:0]          ldr_addr_i,
  input  logic [31:0]          ldr_wdata_i,
  input  logic [3:0]           ldr_wstrb_i,
  output logic                 ldr_ready_o,
  output logic [31:0]          ldr_rdata_o,
  output logic                 ram_en_o,
  output logic [3:0]           ram_we_o,
  output logic [AddrWidth-1:0] ram_addr_o,
  output logic [31:0]          ram_wdata_o,
  input  logic [31:0]          ram_rdata_i,
  output logic                 err_o,
  output state_t               dbg_state
);

  state_t      state, state_next;
  gnt_t        gnt_pick, gnt_q;
  logic        prio_ldr;
  logic        any_valid, grant_now;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_wstrb, wstrb_q;
  logic        sel_oor, oor_q, resp_read;
  logic        unused_addr_bits;

  assign any_valid = cpu_valid_i | ldr_valid_i;
  assign grant_now = (state == IDLE) && any_valid;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_ldr;

  // Reset value "CPU served last" lets the loader win the first tie.
  always_ff @(posedge clk_i) begin
    if (reset_i)        last_ldr <= 1'b0;
    else if (grant_now) last_ldr <= (gnt_pick == GNT_LDR);
  end

  assign prio_ldr = !last_ldr;
`else
  assign prio_ldr = LoaderFirst;
`endif

  mem_arb_pick u_pick (
    .cpu_valid (cpu_valid_i),
    .ldr_valid (ldr_valid_i),
    .prio_ldr  (prio_ldr),
    .gnt       (gnt_pick)
  );

  assign sel_addr  = (gnt_pick == GNT_LDR) ? ldr_addr_i  : cpu_addr_i;
  assign sel_wdata = (gnt_pick == GNT_LDR) ? ldr_wdata_i : cpu_wdata_i;
  assign sel_wstrb = (gnt_pick == GNT_LDR) ? ldr_wstrb_i : cpu_wstrb_i;
  assign sel_oor   = |sel_addr[31:AddrWidth+2];
  assign unused_addr_bits = ^{cpu_addr_i[1:0], ldr_addr_i[1:0]};

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_valid) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      gnt_q       <= GNT_CPU;
      wstrb_q     <= '0;
      oor_q       <= 1'b0;
      err_o       <= 1'b0;
      ram_en_o    <= 1'b0;
      ram_we_o    <= '0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
    end else begin
      state <= state_next;
      // RAM outputs are loaded on the grant edge so they are live exactly for ACCESS.
      if (grant_now) begin
        gnt_q       <= gnt_pick;
        wstrb_q     <= sel_wstrb;
        oor_q       <= sel_oor;
        ram_en_o    <= !sel_oor;
        ram_we_o    <= sel_oor ? 4'h0 : sel_wstrb;
        ram_addr_o  <= sel_oor ? '0 : sel_addr[AddrWidth+1:2];
        ram_wdata_o <= sel_oor ? '0 : sel_wdata;
        if (sel_oor) err_o <= 1'b1;
      end else begin
        ram_en_o    <= 1'b0;
        ram_we_o    <= '0;
        ram_addr_o  <= '0;
        ram_wdata_o <= '0;
      end
    end
  end

  assign resp_read   = (state == RESP) && !oor_q && (wstrb_q == 4'h0);
  assign cpu_ready_o = (state == RESP) && (gnt_q == GNT_CPU);
  assign ldr_ready_o = (state == RESP) && (gnt_q == GNT_LDR);
  assign cpu_rdata_o = (cpu_ready_o && resp_read) ? ram_rdata_i : 32'h0;
  assign ldr_rdata_o = (ldr_ready_o && resp_read) ? ram_rdata_i : 32'h0;
  assign dbg_state   = state;

endmodule

// File: tb/tb_uart_mem_arbiter.sv
// Directed bench for uart_mem_arbiter with a behavioural byte-write synchronous RAM.
module tb_uart_mem_arbiter;
  import uart_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        err;
  state_t      dbg_state;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] mem [0:4095];

  uart_mem_arbiter_if cpu_bus ();
  uart_mem_arbiter_if ldr_bus ();

  always #5 clk = ~clk;

  uart_mem_arbiter dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .cpu_valid_i (cpu_bus.valid),
    .cpu_addr_i  (cpu_bus.addr),
    .cpu_wdata_i (cpu_bus.wdata),
    .cpu_wstrb_i (cpu_bus.wstrb),
    .cpu_ready_o (cpu_bus.ready),
    .cpu_rdata_o (cpu_bus.rdata),
    .ldr_valid_i (ldr_bus.valid),
    .ldr_addr_i  (ldr_bus.addr),
    .ldr_wdata_i (ldr_bus.wdata),
    .ldr_wstrb_i (ldr_bus.wstrb),
    .ldr_ready_o (ldr_bus.ready),
    .ldr_rdata_o (ldr_bus.rdata),
    .ram_en_o    (ram_en),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata),
    .err_o       (err),
    .dbg_state   (dbg_state)
  );

  // Read-first synchronous RAM with byte enables.
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one transaction from an idle bus and checks ACCESS at N+1 and RESP at N+2.
  task automatic do_access(input string tag, input bit use_ldr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           input bit oor, input logic [31:0] exp_rdata);
    if (use_ldr) begin
      ldr_bus.valid = 1'b1; ldr_bus.addr = addr; ldr_bus.wdata = wdata; ldr_bus.wstrb = wstrb;
    end else begin
      cpu_bus.valid = 1'b1; cpu_bus.addr = addr; cpu_bus.wdata = wdata; cpu_bus.wstrb = wstrb;
    end
    tick();
    chk({tag, "_state_access"}, 32'(dbg_state), 32'(ACCESS));
    chk({tag, "_ram_en"}, 32'(ram_en), oor ? 32'd0 : 32'd1);
    chk({tag, "_ram_we"}, 32'(ram_we), oor ? 32'd0 : 32'(wstrb));
    if (!oor) begin
      chk({tag, "_ram_addr"}, 32'(ram_addr), 32'(addr[13:2]));
      chk({tag, "_ram_wdata"}, ram_wdata, wdata);
    end
    tick();
    chk({tag, "_cpu_ready"}, 32'(cpu_bus.ready), use_ldr ? 32'd0 : 32'd1);
    chk({tag, "_ldr_ready"}, 32'(ldr_bus.ready), use_ldr ? 32'd1 : 32'd0);
    chk({tag, "_rdata"}, use_ldr ? ldr_bus.rdata : cpu_bus.rdata, exp_rdata);
    chk({tag, "_other_rdata"}, use_ldr ? cpu_bus.rdata : ldr_bus.rdata, 32'h0);
    tick();
    cpu_bus.valid = 1'b0;
    ldr_bus.valid = 1'b0;
    chk({tag, "_state_idle"}, 32'(dbg_state), 32'(IDLE));
  endtask

  logic exp_ldr_seq [4];

  initial begin
    cpu_bus.valid = 1'b0; cpu_bus.addr = '0; cpu_bus.wdata = '0; cpu_bus.wstrb = '0;
    ldr_bus.valid = 1'b0; ldr_bus.addr = '0; ldr_bus.wdata = '0; ldr_bus.wstrb = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_cpu_ready", 32'(cpu_bus.ready), 32'd0);
    chk("rst_ldr_ready", 32'(ldr_bus.ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    do_access("cpu_wr", 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    do_access("cpu_rd", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);
    do_access("cpu_bwr", 1'b0, 32'h10, 32'h0000AA00, 4'h2, 1'b0, 32'h0);
    do_access("cpu_brd", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADAAEF);
    do_access("ldr_wr", 1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0, 32'h0);
    do_access("cpu_rd20", 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h12345678);

    // Tie: loader writes 0x44, CPU reads 0x44 and must see the loader's data.
    ldr_bus.valid = 1'b1; ldr_bus.addr = 32'h44; ldr_bus.wdata = 32'hCAFEF00D; ldr_bus.wstrb = 4'hF;
    cpu_bus.valid = 1'b1; cpu_bus.addr = 32'h44; cpu_bus.wdata = 32'h0; cpu_bus.wstrb = 4'h0;
    tick();
    chk("tie_we", 32'(ram_we), 32'hF);
    chk("tie_addr", 32'(ram_addr), 32'h11);
    tick();
    chk("tie_ldr_ready", 32'(ldr_bus.ready), 32'd1);
    chk("tie_cpu_ready_n2", 32'(cpu_bus.ready), 32'd0);
    tick();
    ldr_bus.valid = 1'b0;
    chk("tie_state_idle", 32'(dbg_state), 32'(IDLE));
    tick();
    chk("tie_cpu_en", 32'(ram_en), 32'd1);
    chk("tie_cpu_we", 32'(ram_we), 32'h0);
    chk("tie_cpu_ready_n4", 32'(cpu_bus.ready), 32'd0);
    tick();
    chk("tie_cpu_ready", 32'(cpu_bus.ready), 32'd1);
    chk("tie_ldr_ready_n5", 32'(ldr_bus.ready), 32'd0);
    chk("tie_cpu_rdata", cpu_bus.rdata, 32'hCAFEF00D);
    tick();
    cpu_bus.valid = 1'b0;

    chk("pre_oor_err", 32'(err), 32'd0);
    do_access("oor", 1'b0, 32'h0001_0000, 32'h0, 4'h0, 1'b1, 32'h0);
    chk("oor_err", 32'(err), 32'd1);
    tick();
    tick();
    chk("oor_err_sticky", 32'(err), 32'd1);

    // Reset lands during ACCESS of a CPU read.
    cpu_bus.valid = 1'b1; cpu_bus.addr = 32'h10; cpu_bus.wstrb = 4'h0;
    tick();
    chk("rmid_access", 32'(dbg_state), 32'(ACCESS));
    chk("rmid_en", 32'(ram_en), 32'd1);
    reset = 1'b1;
    tick();
    chk("rmid_state", 32'(dbg_state), 32'(IDLE));
    chk("rmid_en_off", 32'(ram_en), 32'd0);
    chk("rmid_addr_off", 32'(ram_addr), 32'd0);
    chk("rmid_no_ready", 32'(cpu_bus.ready), 32'd0);
    chk("rmid_rdata", cpu_bus.rdata, 32'h0);
    chk("rmid_err_clr", 32'(err), 32'd0);
    reset = 1'b0;
    tick();
    chk("rfresh_en", 32'(ram_en), 32'd1);
    chk("rfresh_addr", 32'(ram_addr), 32'h4);
    tick();
    chk("rfresh_ready", 32'(cpu_bus.ready), 32'd1);
    chk("rfresh_rdata", cpu_bus.rdata, 32'hDEADAAEF);
    tick();
    cpu_bus.valid = 1'b0;

    // Both held continuously: grant order depends on the arbitration mode.
`ifdef ARB_ROUND_ROBIN_EN
    exp_ldr_seq[0] = 1'b1; exp_ldr_seq[1] = 1'b0; exp_ldr_seq[2] = 1'b1; exp_ldr_seq[3] = 1'b0;
`else
    exp_ldr_seq[0] = 1'b1; exp_ldr_seq[1] = 1'b1; exp_ldr_seq[2] = 1'b1; exp_ldr_seq[3] = 1'b1;
`endif
    ldr_bus.valid = 1'b1; ldr_bus.addr = 32'h20; ldr_bus.wstrb = 4'h0;
    cpu_bus.valid = 1'b1; cpu_bus.addr = 32'h44; cpu_bus.wstrb = 4'h0;
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      chk($sformatf("hold%0d_ldr_ready", k), 32'(ldr_bus.ready), 32'(exp_ldr_seq[k]));
      chk($sformatf("hold%0d_cpu_ready", k), 32'(cpu_bus.ready), 32'(!exp_ldr_seq[k]));
      chk($sformatf("hold%0d_rdata", k), exp_ldr_seq[k] ? ldr_bus.rdata : cpu_bus.rdata,
          exp_ldr_seq[k] ? 32'h12345678 : 32'hCAFEF00D);
      tick();
    end
    ldr_bus.valid = 1'b0;
    cpu_bus.valid = 1'b0;
    tick();
    chk("end_state", 32'(dbg_state), 32'(IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_mem_arbiter.md
UART_MEM_ARBITER -- requirements
Module: uart_mem_arbiter

Interface
REQ-001 Parameter AddrWidth, default 12: RAM word-address width (4 KiW = 16 KiB).
REQ-002 Parameter LoaderFirst, default 1: fixed-priority winner (1 = loader, 0 = CPU) when ARB_ROUND_ROBIN_EN is undefined.
REQ-003 Port clk_i  in  1: single clock, all logic rising-edge.
REQ-004 Port reset_i  in  1: synchronous, active-high reset.
REQ-005 Ports cpu_valid_i in 1, cpu_addr_i in 32, cpu_wdata_i in 32, cpu_wstrb_i in 4, cpu_ready_o out 1, cpu_rdata_o out 32: picorv32 native memory port (byte address).
REQ-006 Ports ldr_valid_i in 1, ldr_addr_i in 32, ldr_wdata_i in 32, ldr_wstrb_i in 4, ldr_ready_o out 1, ldr_rdata_o out 32: UART loader port, same protocol as CPU port.
REQ-007 Ports ram_en_o out 1, ram_we_o out 4, ram_addr_o out AddrWidth, ram_wdata_o out 32, ram_rdata_i in 32: single-port sync RAM, read data valid one cycle after ram_en_o.
REQ-008 Port err_o  out  1: sticky out-of-range-access flag.

Function
REQ-009 Requester protocol: valid held high with stable addr/wdata/wstrb until ready; ready is a one-cycle pulse; wstrb==0 means read.
REQ-010 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when any valid is high, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-011 In IDLE with a valid present: winner selected per REQ-021/022, its addr/wdata/wstrb and grant registered.
REQ-012 In ACCESS: ram_en_o=1, ram_addr_o=addr[AddrWidth+1:2], ram_we_o=wstrb, ram_wdata_o=wdata; all RAM outputs registered, zero/idle outside ACCESS.
REQ-013 In RESP: only the granted port's ready_o=1; its rdata_o=ram_rdata_i for reads, 0 for writes; non-granted rdata_o=0.
REQ-014 Latency: valid seen in IDLE at cycle N -> ram_en_o at N+1 -> ready_o at N+2; next arbitration no earlier than N+3.
REQ-015 Out-of-range: addr[31:AddrWidth+2] nonzero -> ACCESS with ram_en_o=0, ram_we_o=0; RESP with ready_o=1, rdata_o=0; err_o set, held until reset.
REQ-016 Loser's valid is ignored (not latched); it stays pending and is rearbitrated at the next IDLE.
REQ-017 Valid dropping during ACCESS/RESP does not abort the transaction; ready still pulses.
REQ-018 Simultaneous valid high on both ports: exactly one grant, never both ready_o in one cycle.

Reset
REQ-019 reset_i high at any clock edge, including mid-transaction: state=IDLE, ram_en_o=0, ram_we_o=0, ram_addr_o=0, ram_wdata_o=0, both ready_o=0, both rdata_o=0, err_o=0, round-robin pointer=CPU-last-served (loader wins first tie).
REQ-020 In-flight transaction killed by reset produces no ready pulse; its write may or may not have reached RAM if reset coincides with ACCESS.

Configuration
REQ-021 ARB_ROUND_ROBIN_EN defined: on tie, the port not served last wins; pointer updated on every grant, including out-of-range.
REQ-022 ARB_ROUND_ROBIN_EN undefined: on tie, LoaderFirst decides; no pointer register exists.

Structure
REQ-023 Shared package uart_mem_pkg holds the FSM state enum (IDLE/ACCESS/RESP), grant enum (GNT_CPU/GNT_LDR) and default RAM_ADDR_WIDTH constant.
REQ-024 One sub-module, mem_arb_pick: combinational 2-way picker (valid vector, pointer/priority -> grant); FSM and registers stay in uart_mem_arbiter.

Verification
REQ-025 CPU write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, then read 0x10 -> ram_addr_o=4 at N+1, cpu_ready_o at N+2, read returns 0xDEADBEEF.
REQ-026 Byte write addr 0x10, wstrb 0x2, wdata 0x0000AA00 after REQ-025 -> read returns 0xDEADAAEF.
REQ-027 Both valid high same cycle, fixed mode LoaderFirst=1 -> ldr_ready_o at N+2, cpu_ready_o at N+5; with ARB_ROUND_ROBIN_EN and both held continuously -> grants alternate L,C,L,C.
REQ-028 CPU read addr 0x0001_0000 (AddrWidth=12) -> ram_en_o never high, cpu_ready_o at N+2 with rdata 0, err_o=1 until reset.
REQ-029 reset_i asserted in ACCESS of a CPU read -> next cycle IDLE, no ready pulse, all outputs zero; a fresh read after release completes in 3 cycles.
